// File: rtl/io_port_responder_if.sv
// CPU-facing strobes and the two valid/ready streams of io_port_responder.
// The tristate data bus stays a plain inout port on the responder.
interface io_port_responder_if;
   logic        io_read;
   logic        io_write;
   logic        io_push;
   logic [15:0] d_addr;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;

   modport master (
      output io_read, io_write, io_push, d_addr, tx_ready, rx_data, rx_valid,
      input  tx_data, tx_valid, rx_ready
   );

   modport slave (
      input  io_read, io_write, io_push, d_addr, tx_ready, rx_data, rx_valid,
      output tx_data, tx_valid, rx_ready
   );
endinterface

// File: rtl/io_port_responder.sv
// io_port_responder: device-side responder for the CPU IO interface.
// Decodes io_read/io_write/io_push against d_addr[3:0], provides four output
// latches, four input ports, a TX FIFO drained over valid/ready, an RX FIFO
// filled over valid/ready and a status register with two sticky flags.
// Optional feature macro: IO_SYNC_EN -- when defined, in_ports passes through
// a 2-flop synchronizer before being readable at 0x4-0x7.
module io_port_responder #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   io_port_responder_if.slave  bus,
   inout  wire  [15:0]         d_bus,
   output logic [63:0]         out_ports,
   input  logic [63:0]         in_ports
);

   localparam int         DATA_W  = 16;
   localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

   // ---------------------------------------------------------------------
   // Address decode and strobe qualification
   // ---------------------------------------------------------------------
   logic [3:0] addr;
   logic       unused_addr_hi;
   logic       rd_act;
   logic       stat_clr;
   logic       out_wr;

   assign addr           = bus.d_addr[3:0];
   assign unused_addr_hi = ^bus.d_addr[15:4];
   // A read that collides with a write or push is dropped entirely.
   assign rd_act         = bus.io_read & ~bus.io_write & ~bus.io_push;
   assign stat_clr       = bus.io_write & (addr == 4'hA);
   assign out_wr         = bus.io_write & (addr[3:2] == 2'b00);

   // ---------------------------------------------------------------------
   // Output latches
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] out_regs [4];

   // Latch CPU write data into the addressed output port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) out_regs[i] <= '0;
      end else if (out_wr) begin
         out_regs[addr[1:0]] <= d_bus;
      end
   end

   assign out_ports = {out_regs[3], out_regs[2], out_regs[1], out_regs[0]};

   // ---------------------------------------------------------------------
   // Input ports (optionally synchronized)
   // ---------------------------------------------------------------------
   logic [63:0] in_view;

`ifdef IO_SYNC_EN
   logic [63:0] in_sync_p0;
   logic [63:0] in_sync_p1;

   // Two-flop synchronizer on every input port bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_sync_p0 <= '0;
         in_sync_p1 <= '0;
      end else begin
         in_sync_p0 <= in_ports;
         in_sync_p1 <= in_sync_p0;
      end
   end

   assign in_view = in_sync_p1;
`else
   assign in_view = in_ports;
`endif

   // ---------------------------------------------------------------------
   // TX FIFO (CPU pushes, stream drains, first-word-fall-through)
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [AW-1:0]     tx_wr_ptr;
   logic [AW-1:0]     tx_rd_ptr;
   logic [3:0]        tx_count;
   logic              tx_overflow;
   logic              tx_full;
   logic              tx_empty;
   logic              tx_push_req;
   logic              tx_push;
   logic              tx_pop;

   assign tx_full     = (tx_count == DEPTH_C);
   assign tx_empty    = (tx_count == 4'd0);
   // io_push and a write to 0x8 in the same cycle collapse to one push.
   assign tx_push_req = bus.io_push | (bus.io_write & (addr == 4'h8));
   // Space is judged on the registered count; a same-cycle drain does not help.
   assign tx_push     = tx_push_req & ~tx_full;
   assign tx_pop      = ~tx_empty & bus.tx_ready;

   // TX pointers, occupancy count and overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr_ptr   <= '0;
         tx_rd_ptr   <= '0;
         tx_count    <= '0;
         tx_overflow <= 1'b0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 4'd1;
            2'b01:   tx_count <= tx_count - 4'd1;
            default: tx_count <= tx_count;
         endcase
         // A fresh overflow in the clearing cycle is kept.
         if (stat_clr)               tx_overflow <= 1'b0;
         if (tx_push_req & tx_full)  tx_overflow <= 1'b1;
      end
   end

   // TX storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= d_bus;
   end

   assign bus.tx_data  = tx_mem[tx_rd_ptr];
   assign bus.tx_valid = ~tx_empty;

   // ---------------------------------------------------------------------
   // RX FIFO (stream fills, CPU reads at 0x9 pop)
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     rx_wr_ptr;
   logic [AW-1:0]     rx_rd_ptr;
   logic [3:0]        rx_count;
   logic              rx_underflow;
   logic              rx_full;
   logic              rx_empty;
   logic              rx_fill;
   logic              rx_pop_req;
   logic              rx_pop;

   assign rx_full      = (rx_count == DEPTH_C);
   assign rx_empty     = (rx_count == 4'd0);
   assign rx_fill      = bus.rx_valid & ~rx_full;
   assign rx_pop_req   = rd_act & (addr == 4'h9);
   assign rx_pop       = rx_pop_req & ~rx_empty;
   assign bus.rx_ready = ~rx_full;

   // RX pointers, occupancy count and underflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wr_ptr    <= '0;
         rx_rd_ptr    <= '0;
         rx_count     <= '0;
         rx_underflow <= 1'b0;
      end else begin
         if (rx_fill) rx_wr_ptr <= rx_wr_ptr + AW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
         case ({rx_fill, rx_pop})
            2'b10:   rx_count <= rx_count + 4'd1;
            2'b01:   rx_count <= rx_count - 4'd1;
            default: rx_count <= rx_count;
         endcase
         if (stat_clr)                rx_underflow <= 1'b0;
         if (rx_pop_req & rx_empty)   rx_underflow <= 1'b1;
      end
   end

   // RX storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (rx_fill) rx_mem[rx_wr_ptr] <= bus.rx_data;
   end

   // ---------------------------------------------------------------------
   // Read mux and bus drive
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] rd_data;

   assign status = {2'b00, rx_underflow, tx_overflow,
                    rx_empty, rx_full, tx_empty, tx_full,
                    rx_count, tx_count};

   // Combinational read data selected by the low address nibble.
   always_comb begin
      rd_data = '0;
      case (addr)
         4'h0, 4'h1, 4'h2, 4'h3: rd_data = out_regs[addr[1:0]];
         4'h4, 4'h5, 4'h6, 4'h7: rd_data = in_view[{addr[1:0], 4'b0000} +: DATA_W];
         4'h9:                   rd_data = rx_empty ? '0 : rx_mem[rx_rd_ptr];
         4'hA:                   rd_data = status;
         default:                rd_data = '0;
      endcase
   end

   assign d_bus = rd_act ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_io_port_responder;

   localparam int DEPTH = 8;

   logic        clk;
   logic        rst;
   logic [63:0] out_ports;
   logic [63:0] in_ports;
   wire  [15:0] d_bus;
   logic [15:0] cpu_data;
   logic        cpu_drive;

   io_port_responder_if bus ();

   assign d_bus = cpu_drive ? cpu_data : 16'hzzzz;

   io_port_responder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .d_bus     (d_bus),
      .out_ports (out_ports),
      .in_ports  (in_ports)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   logic [15:0] txq[$];
   logic [15:0] rxq[$];
   logic [15:0] m_out [4];
   logic        m_txo, m_rxu;
   logic [63:0] m_in_d1, m_in_d2;

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      m_txo   = 1'b0;
      m_rxu   = 1'b0;
      m_in_d1 = '0;
      m_in_d2 = '0;
   endtask

   function automatic logic [15:0] model_status();
      int tc;
      int rc;
      tc = txq.size();
      rc = rxq.size();
      return {2'b00, m_rxu, m_txo, rc == 0, rc == DEPTH, tc == 0, tc == DEPTH,
              rc[3:0], tc[3:0]};
   endfunction

   function automatic logic [63:0] model_inputs();
`ifdef IO_SYNC_EN
      return m_in_d2;
`else
      return in_ports;
`endif
   endfunction

   function automatic logic [15:0] model_read(input logic [3:0] a);
      logic [63:0] iv;
      iv = model_inputs();
      if (a < 4)       return m_out[a[1:0]];
      else if (a < 8)  return iv[16*(a-4) +: 16];
      else if (a == 9) return (rxq.size() != 0) ? rxq[0] : 16'h0000;
      else if (a == 10) return model_status();
      else             return 16'h0000;
   endfunction

   // ---------------- stimulus helpers ----------------
   logic [15:0] last_bus;
   logic [15:0] last_txd;
   logic        last_txv;
   logic        last_rxr;
   logic        tx_rdy;
   logic [63:0] cur_in;

   task automatic drive_idle();
      bus.io_read  = 1'b0;
      bus.io_write = 1'b0;
      bus.io_push  = 1'b0;
      bus.d_addr   = '0;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      cpu_data     = '0;
      cpu_drive    = 1'b0;
   endtask

   task automatic step(input logic rd, input logic wr, input logic ps,
                       input logic [15:0] addr, input logic [15:0] data,
                       input logic txr, input logic rxv, input logic [15:0] rxd,
                       input logic [63:0] inp);
      logic [3:0] a;
      logic       rd_act, push_req, do_push, do_txpop, do_fill, pop_req, do_rxpop;
      @(negedge clk);
      bus.io_read  = rd;
      bus.io_write = wr;
      bus.io_push  = ps;
      bus.d_addr   = addr;
      bus.tx_ready = txr;
      bus.rx_valid = rxv;
      bus.rx_data  = rxd;
      in_ports     = inp;
      cpu_data     = data;
      cpu_drive    = wr | ps;
      #2;
      a      = addr[3:0];
      rd_act = rd && !wr && !ps;
      last_bus = d_bus;
      last_txd = bus.tx_data;
      last_txv = bus.tx_valid;
      last_rxr = bus.rx_ready;
      check("out_ports", out_ports, {m_out[3], m_out[2], m_out[1], m_out[0]});
      check("tx_valid", bus.tx_valid, txq.size() != 0);
      if (txq.size() != 0) check("tx_data", bus.tx_data, txq[0]);
      check("rx_ready", bus.rx_ready, rxq.size() < DEPTH);
      if (rd_act) check("d_bus_read", d_bus, model_read(a));
      push_req = ps || (wr && a == 4'h8);
      do_push  = push_req && txq.size() < DEPTH;
      do_txpop = txr && txq.size() != 0;
      do_fill  = rxv && rxq.size() < DEPTH;
      pop_req  = rd_act && a == 4'h9;
      do_rxpop = pop_req && rxq.size() != 0;
      @(posedge clk);
      if (wr && a == 4'hA) begin
         m_txo = 1'b0;
         m_rxu = 1'b0;
      end
      if (push_req && !do_push) m_txo = 1'b1;
      if (pop_req && !do_rxpop) m_rxu = 1'b1;
      if (do_txpop) void'(txq.pop_front());
      if (do_push)  txq.push_back(data);
      if (do_rxpop) void'(rxq.pop_front());
      if (do_fill)  rxq.push_back(rxd);
      if (wr && a < 4) m_out[a[1:0]] = data;
      m_in_d2 = m_in_d1;
      m_in_d1 = inp;
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
      step(1'b0, 1'b1, 1'b0, addr, data, tx_rdy, 1'b0, 16'h0, cur_in);
   endtask

   task automatic cpu_read(input logic [15:0] addr);
      step(1'b1, 1'b0, 1'b0, addr, 16'h0, tx_rdy, 1'b0, 16'h0, cur_in);
   endtask

   task automatic cpu_push(input logic [15:0] data);
      step(1'b0, 1'b0, 1'b1, 16'($urandom), data, tx_rdy, 1'b0, 16'h0, cur_in);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, tx_rdy, 1'b0, 16'h0, cur_in);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0] nib;
      int         kind;
      logic [15:0] addr;

      rst      = 1'b1;
      in_ports = '0;
      cur_in   = '0;
      tx_rdy   = 1'b0;
      drive_idle();
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_out_ports", out_ports, 64'h0);
      check("rst_tx_valid", bus.tx_valid, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_rx_ready", bus.rx_ready, 1'b1);

      // Output latch write and readback.
      cpu_write(16'h0001, 16'hBEEF);
      #1;
      check("out_port1", out_ports[31:16], 16'hBEEF);
      check("out_others", {out_ports[63:32], out_ports[15:0]}, 48'h0);
      cpu_read(16'hF001);
      check("read_port1", last_bus, 16'hBEEF);

      // TX overflow with sink stalled, then drain.
      for (int i = 1; i <= 9; i++) cpu_push(16'(i));
      cpu_read(16'h000A);
      check("status_tx_full", last_bus, 16'h1908);
      tx_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         idle();
         check("tx_seq_valid", last_txv, 1'b1);
         check("tx_seq_data", last_txd, 16'(i + 1));
      end
      idle();
      check("tx_drained", last_txv, 1'b0);
      tx_rdy = 1'b0;

      // RX fill to full, drain by CPU reads, then underflow.
      for (int i = 0; i < 8; i++)
         step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'hA000 + 16'(i), cur_in);
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'hDEAD, cur_in);
      check("rx_full_ready", last_rxr, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cpu_read(16'h0009);
         check("rx_seq", last_bus, 16'hA000 + 16'(i));
      end
      cpu_read(16'h0009);
      check("rx_underflow_data", last_bus, 16'h0000);
      cpu_read(16'h000A);
      check("status_sticky", last_bus, 16'h3A00);

      // Clear sticky flags; unmapped read.
      cpu_write(16'h000A, 16'(($urandom)));
      cpu_read(16'h000A);
      check("status_cleared", last_bus, 16'h0A00);
      cpu_read(16'h000C);
      check("read_unmapped", last_bus, 16'h0000);

      // Input port read latency.
      cur_in = {16'h1234, 48'h0};
`ifdef IO_SYNC_EN
      idle();
      idle();
`endif
      cpu_read(16'h0007);
      check("in_port3", last_bus, 16'h1234);

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         kind   = $urandom_range(0, 11);
         nib    = 4'($urandom_range(0, 15));
         if (kind < 3 && $urandom_range(0, 1) == 1) nib = ($urandom_range(0, 1) == 1) ? 4'h9 : 4'hA;
         addr   = {12'($urandom), nib};
         cur_in = {$urandom, $urandom};
         tx_rdy = ($urandom_range(0, 2) == 0);
         case (kind)
            0, 1, 2: step(1'b1, 1'b0, 1'b0, addr, 16'($urandom), tx_rdy, $urandom_range(0, 1) == 1, 16'($urandom), cur_in);
            3, 4:    step(1'b0, 1'b1, 1'b0, addr, 16'($urandom), tx_rdy, $urandom_range(0, 1) == 1, 16'($urandom), cur_in);
            5, 6:    step(1'b0, 1'b0, 1'b1, addr, 16'($urandom), tx_rdy, $urandom_range(0, 1) == 1, 16'($urandom), cur_in);
            7:       step(1'b1, 1'b1, 1'b0, addr, 16'($urandom), tx_rdy, $urandom_range(0, 1) == 1, 16'($urandom), cur_in);
            8:       step(1'b1, 1'b0, 1'b1, addr, 16'($urandom), tx_rdy, $urandom_range(0, 1) == 1, 16'($urandom), cur_in);
            9:       step(1'b0, 1'b1, 1'b1, addr, 16'($urandom), tx_rdy, $urandom_range(0, 1) == 1, 16'($urandom), cur_in);
            default: step(1'b0, 1'b0, 1'b0, addr, 16'h0, tx_rdy, $urandom_range(0, 1) == 1, 16'($urandom), cur_in);
         endcase
      end

      // Asynchronous reset with TX holding three entries.
      cur_in = '0;
      tx_rdy = 1'b1;
      repeat (10) idle();
      tx_rdy = 1'b0;
      cpu_write(16'h0002, 16'h5555);
      for (int i = 0; i < 3; i++) cpu_push(16'hC000 + 16'(i));
      #3;
      check("pre_rst_tx_valid", bus.tx_valid, 1'b1);
      rst = 1'b1;
      drive_idle();
      #1;
      check("async_rst_tx_valid", bus.tx_valid, 1'b0);
      check("async_rst_out_ports", out_ports, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cpu_read(16'h000A);
      check("post_rst_status", last_bus, 16'h0A00);
      check("post_rst_rx_ready", last_rxr, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
